led_counter_ctrl: RTL and testbench
===================================

Name: led_counter_ctrl

Overview:
User-input front end for the LED up/down counter stage. It synchronises and debounces three push-buttons and lets the user edit the start and end values, then issues a one-cycle load pulse. It generates the prescaled count-enable tick and stops ticking when the counter reports completion. Sits directly upstream of the counter: drives its start_num/end_num/up_down/load/enable inputs and consumes its check flag.

Parameters:
W, 5, width of start/end values
DEB_CYCLES, 1000000, consecutive stable samples before a debounced level changes (min 2)
TICK_DIV, 50000000, clk cycles per cnt_en pulse (min 2)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
btn_inc  in  1  raw button, async to clk, active-high: increment value being edited
btn_dec  in  1  raw button, async, active-high: decrement value being edited
btn_next  in  1  raw button, async, active-high: advance state
cnt_done  in  1  completion flag (check) from the counter
start_num  out  W  registered start value
end_num  out  W  registered end value
up_down  out  1  direction: 1 = count up, 0 = count down
load  out  1  one-cycle pulse: counter preloads start_num
cnt_en  out  1  one-cycle count-enable tick
state_o  out  2  current state: 0 EDIT_START, 1 EDIT_END, 2 RUN, 3 DONE

Behaviour:
- Reset values: start_num=0, end_num=2^W-1, up_down=1, load=0, cnt_en=0, state_o=0. Synchronisers, debounced levels, debounce counters and prescaler are all cleared. Reset asserted mid-operation aborts immediately to these values.
- Input path, per button: 2-FF synchroniser, then a debounce counter.
  - The counter increments while the synced level differs from the debounced level and clears when they match.
  - On reaching DEB_CYCLES-1, the debounced level takes the synced level.
  - A debounced rising edge produces one press pulse (1 cycle). Falling edges produce nothing.
  - Press pulse latency from a clean input edge: 2 sync cycles + DEB_CYCLES + 1.
- Press priority when pulses coincide: next > inc > dec. Only the highest-priority press acts that cycle; the others are dropped.
- EDIT_START:
  - inc: start_num+1, wrapping 2^W-1 -> 0.
  - dec: start_num-1, wrapping 0 -> 2^W-1.
  - next -> EDIT_END.
- EDIT_END:
  - inc/dec edit end_num with the same wrap rules.
  - next -> RUN. In that same cycle: up_down <= (end_num >= start_num), load pulses for exactly 1 cycle, prescaler cleared, armed flag cleared.
- RUN:
  - inc/dec ignored.
  - Prescaler counts 0..TICK_DIV-1 and wraps. cnt_en=1 for the single cycle when prescaler==TICK_DIV-1. The first tick occurs TICK_DIV cycles after load.
  - armed flag sets on the first cnt_en. cnt_done is ignored while armed=0, masking the stale flag left over from before load.
  - cnt_done=1 with armed=1 -> DONE.
  - next -> DONE (user abort); it takes priority over cnt_done.
- DONE:
  - cnt_en held 0, prescaler held.
  - inc/dec ignored.
  - next -> EDIT_START. start_num and end_num are retained for re-editing.
- start_num == end_num is legal: up_down=1, and the counter completes on its first evaluated tick.
- start_num, end_num, up_down change only in the states/cycles stated above and are stable throughout RUN.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
(Bench uses W=5, DEB_CYCLES=3, TICK_DIV=4.)
- Reset: assert rst mid-RUN -> same cycle: state_o=0, start_num=0, end_num=31, up_down=1, load=0, cnt_en=0.
- Bounce: btn_inc toggles every cycle for 10 cycles, then held high 6 cycles -> exactly one increment, start_num 0->1. A 2-cycle glitch produces no change.
- Wrap: in EDIT_START press dec once -> start_num=31; press inc twice -> start_num=1. In EDIT_END with end_num=31, press inc -> end_num=0.
- Run: start=3, end=7, press next -> one load pulse, up_down=1, cnt_en pulses every 4 cycles, the first one 4 cycles after load. Hold cnt_done=1 from load onward -> no DONE before the first tick; DONE on the cycle after cnt_done is sampled with armed=1. cnt_en stays 0 afterwards.
- Down: start=9, end=2 -> up_down=0 at load. start=end=5 -> up_down=1.
- Priority/abort: next and inc pressed in the same cycle in EDIT_START -> state EDIT_END, start_num unchanged. next pressed during RUN -> DONE, no further cnt_en. next in DONE -> EDIT_START, values retained.

Source files
------------

// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: button front end for the LED up/down counter stage.
// It synchronises and debounces three buttons and lets the user edit the
// start and end values. It then loads the counter, generates the prescaled
// count-enable tick and stops ticking once the counter reports completion.
module led_counter_ctrl #(
  parameter int unsigned W          = 5,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned TICK_DIV   = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_inc,
  input  logic         btn_dec,
  input  logic         btn_next,
  input  logic         cnt_done,
  output logic [W-1:0] start_num,
  output logic [W-1:0] end_num,
  output logic         up_down,
  output logic         load,
  output logic         cnt_en,
  output logic [1:0]   state_o
);

  localparam int unsigned DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_EDIT_START = 2'd0,
    S_EDIT_END   = 2'd1,
    S_RUN        = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  // Button bit order: [0] inc, [1] dec, [2] next
  logic [2:0]         btn_raw;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         deb_q, deb_d, deb_prev_q;
  logic [2:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]         press;
  logic               press_inc, press_dec, press_next;

  state_t             state_q, state_d;
  logic [W-1:0]       start_q, start_d;
  logic [W-1:0]       end_q, end_d;
  logic               up_q, up_d;
  logic               load_q, load_d;
  logic               cnt_en_q, cnt_en_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic               armed_q, armed_d;

  assign btn_raw = {btn_next, btn_dec, btn_inc};

  // Synchroniser, debounce state and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // Debounce: the level follows the synced input only after it has differed for DEB_CYCLES samples
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Press pulses on debounced rising edges; next beats inc beats dec
  always_comb begin
    press      = deb_q & ~deb_prev_q;
    press_next = press[2];
    press_inc  = press[0] & ~press[2];
    press_dec  = press[1] & ~press[2] & ~press[0];
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_EDIT_START;
      start_q  <= '0;
      end_q    <= '1;
      up_q     <= 1'b1;
      load_q   <= 1'b0;
      cnt_en_q <= 1'b0;
      pre_q    <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      end_q    <= end_d;
      up_q     <= up_d;
      load_q   <= load_d;
      cnt_en_q <= cnt_en_d;
      pre_q    <= pre_d;
      armed_q  <= armed_d;
    end
  end

  // Next-state, value editing, load/tick generation
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    end_d    = end_q;
    up_d     = up_q;
    load_d   = 1'b0;
    cnt_en_d = 1'b0;
    pre_d    = pre_q;
    armed_d  = armed_q;
    case (state_q)
      S_EDIT_START: begin
        if (press_next) begin
          state_d = S_EDIT_END;
        end else if (press_inc) begin
          start_d = start_q + W'(1);
        end else if (press_dec) begin
          start_d = start_q - W'(1);
        end
      end
      S_EDIT_END: begin
        if (press_next) begin
          state_d = S_RUN;
          up_d    = (end_q >= start_q);
          load_d  = 1'b1;
          pre_d   = '0;
          armed_d = 1'b0;
        end else if (press_inc) begin
          end_d = end_q + W'(1);
        end else if (press_dec) begin
          end_d = end_q - W'(1);
        end
      end
      S_RUN: begin
        // armed follows the registered tick, so the counter has evaluated
        // at least one tick before its completion flag is trusted
        armed_d = armed_q | cnt_en_q;
        pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        if (press_next) begin
          state_d = S_DONE;
        end else if (cnt_done && armed_q) begin
          state_d = S_DONE;
        end else begin
          cnt_en_d = (pre_q == PRE_LAST);
        end
      end
      S_DONE: begin
        if (press_next) begin
          state_d = S_EDIT_START;
        end
      end
      default: state_d = S_EDIT_START;
    endcase
  end

  assign start_num = start_q;
  assign end_num   = end_q;
  assign up_down   = up_q;
  assign load      = load_q;
  assign cnt_en    = cnt_en_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Bench for led_counter_ctrl: directed scenarios and random button and
// done traffic. Every cycle, the outputs are compared with a behavioural
// model that works on sample histories and cycle counts.
module tb_led_counter_ctrl;

  localparam int unsigned W    = 5;
  localparam int unsigned DEB  = 3;
  localparam int unsigned TICK = 4;
  localparam int          MAXV = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         btn_inc = 1'b0, btn_dec = 1'b0, btn_next = 1'b0;
  logic         cnt_done = 1'b0;
  logic [W-1:0] start_num, end_num;
  logic         up_down, load, cnt_en;
  logic [1:0]   state_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  led_counter_ctrl #(.W(W), .DEB_CYCLES(DEB), .TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_next(btn_next),
    .cnt_done(cnt_done),
    .start_num(start_num), .end_num(end_num), .up_down(up_down),
    .load(load), .cnt_en(cnt_en), .state_o(state_o)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_hist[b][0] is the newest raw sample. A debounced level flips once the
  // raw samples taken 2..DEB+1 edges ago all disagree with it. A press acts
  // one edge after its rising flip.
  bit m_hist [3][DEB+1];
  bit m_deb  [3];
  bit m_pend [3];
  int m_state, m_start, m_end, m_age;
  bit m_up, m_load, m_en, m_armed;

  always @(posedge clk or posedge rst) begin
    bit pn, pi, pd, old_en, all_diff, armed_use;
    bit raw [3];
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        for (int i = 0; i <= DEB; i++) m_hist[b][i] = 1'b0;
        m_deb[b]  = 1'b0;
        m_pend[b] = 1'b0;
      end
      m_state = 0; m_start = 0; m_end = MAXV - 1; m_up = 1'b1;
      m_load = 1'b0; m_en = 1'b0; m_armed = 1'b0; m_age = 0;
    end else begin
      pn = m_pend[2];
      pi = m_pend[0] && !pn;
      pd = m_pend[1] && !pn && !m_pend[0];
      raw[0] = btn_inc; raw[1] = btn_dec; raw[2] = btn_next;
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int i = 1; i <= DEB; i++) if (m_hist[b][i] == m_deb[b]) all_diff = 1'b0;
        m_pend[b] = 1'b0;
        if (all_diff) begin
          m_deb[b]  = !m_deb[b];
          m_pend[b] = m_deb[b];
        end
        for (int i = DEB; i >= 1; i--) m_hist[b][i] = m_hist[b][i-1];
        m_hist[b][0] = raw[b];
      end
      old_en = m_en;
      m_load = 1'b0;
      m_en   = 1'b0;
      case (m_state)
        0: if (pn) m_state = 1;
           else if (pi) m_start = (m_start + 1) % MAXV;
           else if (pd) m_start = (m_start + MAXV - 1) % MAXV;
        1: if (pn) begin
             m_state = 2; m_up = (m_end >= m_start); m_load = 1'b1;
             m_age = 0; m_armed = 1'b0;
           end
           else if (pi) m_end = (m_end + 1) % MAXV;
           else if (pd) m_end = (m_end + MAXV - 1) % MAXV;
        2: begin
             armed_use = m_armed;
             m_armed   = m_armed | old_en;
             if (pn) m_state = 3;
             else if (cnt_done && armed_use) m_state = 3;
             else begin
               m_age++;
               m_en = (m_age % TICK) == 0;
             end
           end
        default: if (pn) m_state = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("state_o",   state_o,   m_state);
      check("start_num", start_num, m_start);
      check("end_num",   end_num,   m_end);
      check("up_down",   up_down,   m_up);
      check("load",      load,      m_load);
      check("cnt_en",    cnt_en,    m_en);
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input bit nx, input bit inc, input bit dec);
    btn_next = nx; btn_inc = inc; btn_dec = dec;
    repeat (8) @(negedge clk);
    btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic press_n(input bit inc, input int n);
    for (int i = 0; i < n; i++) press(1'b0, inc, !inc);
  endtask

  initial begin
    #1 rst = 1'b1;
    #22 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_state", state_o, 0);
    check("rst_start", start_num, 0);
    check("rst_end",   end_num, 31);
    check("rst_up",    up_down, 1);
    check("rst_load",  load, 0);
    check("rst_cnten", cnt_en, 0);

    // Bouncing button, then held: one increment only
    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      @(negedge clk);
    end
    btn_inc = 1'b1;
    repeat (6) @(negedge clk);
    btn_inc = 1'b0;
    repeat (8) @(negedge clk);
    check("bounce_start", start_num, 1);

    // Short glitch: ignored
    btn_inc = 1'b1;
    repeat (2) @(negedge clk);
    btn_inc = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_start", start_num, 1);

    // Wrap in EDIT_START
    press_n(1'b0, 1);
    check("dec_to_0", start_num, 0);
    press_n(1'b0, 1);
    check("wrap_down", start_num, 31);
    press_n(1'b1, 2);
    check("wrap_up", start_num, 1);
    press_n(1'b1, 2);
    check("start_3", start_num, 3);

    // EDIT_END wrap
    press(1'b1, 1'b0, 1'b0);
    check("to_edit_end", state_o, 1);
    press_n(1'b1, 1);
    check("end_wrap", end_num, 0);
    press_n(1'b1, 7);
    check("end_7", end_num, 7);

    // Run with a stale done flag held from load onward
    cnt_done = 1'b1;
    btn_next = 1'b1;
    for (int i = 0; i < 30 && load !== 1'b1; i++) @(negedge clk);
    check("load_seen", load, 1);
    check("run_up", up_down, 1);
    repeat (3) @(negedge clk);
    check("no_tick_yet", cnt_en, 0);
    @(negedge clk);
    check("first_tick", cnt_en, 1);
    @(negedge clk);
    check("masked_done", state_o, 2);
    @(negedge clk);
    check("done_state", state_o, 3);
    btn_next = 1'b0;
    repeat (8) @(negedge clk);
    cnt_done = 1'b0;
    check("done_hold", state_o, 3);

    press(1'b1, 1'b0, 1'b0);
    check("back_edit", state_o, 0);
    check("keep_start", start_num, 3);
    check("keep_end", end_num, 7);

    // Down count: start 9, end 2
    press_n(1'b1, 6);
    press(1'b1, 1'b0, 1'b0);
    press_n(1'b0, 5);
    press(1'b1, 1'b0, 1'b0);
    check("down_state", state_o, 2);
    check("down_up", up_down, 0);
    repeat (12) @(negedge clk);
    press(1'b1, 1'b0, 1'b0);
    check("abort_done", state_o, 3);
    repeat (8) @(negedge clk);
    press(1'b1, 1'b0, 1'b0);
    check("abort_back", state_o, 0);

    // Equal values: start 5, end 5
    press_n(1'b0, 4);
    press(1'b1, 1'b0, 1'b0);
    press_n(1'b1, 3);
    press(1'b1, 1'b0, 1'b0);
    check("eq_up", up_down, 1);
    check("eq_start", start_num, 5);
    check("eq_end", end_num, 5);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);

    // next and inc together: next wins, inc dropped
    press(1'b1, 1'b1, 1'b0);
    check("prio_state", state_o, 1);
    check("prio_start", start_num, 5);

    // Reset in the middle of RUN
    press(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_state", state_o, 0);
    check("mrst_start", start_num, 0);
    check("mrst_end",   end_num, 31);
    check("mrst_up",    up_down, 1);
    check("mrst_load",  load, 0);
    check("mrst_cnten", cnt_en, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) btn_inc  = ~btn_inc;
      if ($urandom_range(0, 7) == 0) btn_dec  = ~btn_dec;
      if ($urandom_range(0, 9) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 15) == 0) cnt_done = ~cnt_done;
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
